buffer_read_requester: RTL and testbench
========================================

# buffer_read_requester

Initiator for the read side of the triple-buffer arbitration protocol that `BufferController` serves. It sits between the display/readout pipeline and the buffer controller. It requests a read buffer, latches the granted buffer index, and presents the index plus its SDRAM base address to the reader for one frame. When the reader reports the frame is consumed, it releases the buffer with a finalize pulse.

## Interface
- `ADDR_WIDTH`, 21: width of `frame_base_addr`.
- `FRAME_STRIDE`, 21'h40000: words per frame buffer; base address = id × stride.
- `TIMEOUT_CYCLES`, 65535: cycles in REQUEST without grant before `timeout` is raised.
- `LOG_LEVEL`, `SVL_VERBOSE_INFO`: simulation logger verbosity.

Ports:
- `clk` in 1: system clock, the same clock as `BufferController`.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_rq` in 1: reader wants a new frame; sampled only in IDLE.
- `frame_done` in 1: reader finished the current frame; sampled only in ACTIVE.
- `frame_ready` out 1: buffer owned; `frame_buffer_id` and `frame_base_addr` are valid.
- `frame_buffer_id` out 2: granted buffer index.
- `frame_base_addr` out ADDR_WIDTH: `frame_buffer_id` × `FRAME_STRIDE`, truncated to ADDR_WIDTH.
- `read_rq_rdy` out 1: request to the controller (connects to `read_rq_rdy`).
- `finalize_rd` out 1: release pulse to the controller.
- `buffer_id_valid` in 1: grant strobe from the controller.
- `buffer_id` in 2: granted index from the controller.
- `timeout` out 1: sticky; no grant within TIMEOUT_CYCLES.
- `proto_err` out 1: sticky; controller granted id 3.

## Operation
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- All outputs are registered.
- States:
  - IDLE: `frame_rq`=1 → REQUEST; `read_rq_rdy`=1 from the next cycle.
  - REQUEST: hold `read_rq_rdy`=1 and count cycles. On `buffer_id_valid`=1:
    - id ≤ 2: latch id, drop `read_rq_rdy`, go to RELEASE.
    - id = 3: set `proto_err`, do not latch, drop `read_rq_rdy`, go to RELEASE_ERR.
  - RELEASE: wait for `buffer_id_valid`=0 → ACTIVE; `frame_ready`=1 from the next cycle.
  - RELEASE_ERR: wait for `buffer_id_valid`=0 → REQUEST; re-request from the next cycle and clear the counter.
  - ACTIVE: hold `frame_ready`, id and address stable. `frame_done`=1 → FINALIZE; `frame_ready`=0 and `finalize_rd`=1 from the next cycle.
  - FINALIZE: exactly one cycle with `finalize_rd`=1 → IDLE.
- Timeout:
  - The counter saturates.
  - When count == TIMEOUT_CYCLES-1, `timeout` sets.
  - The request stays asserted; a later grant proceeds normally.
  - `timeout` and `proto_err` clear only on reset.
- `frame_rq` outside IDLE is ignored (not queued). `frame_done` outside ACTIVE is ignored.
- Simultaneous `frame_rq` and `frame_done` in ACTIVE: `frame_done` wins and `frame_rq` is dropped. The reader must re-assert `frame_rq` after `frame_ready` falls.
- Base address is computed when the id is latched and registered with it. Width is ADDR_WIDTH; overflow bits are discarded.
- `frame_buffer_id` and `frame_base_addr` keep their last value after release. They are meaningful only while `frame_ready`=1.
- Reset mid-handshake: all outputs drop to 0 asynchronously. The controller is reset from the same `reset_n`, so no finalize is owed.
- Simulation only: log each grant (info), protocol error (error), and timeout (warning) via DataLogger.

## Timing
- `frame_rq` sampled at edge N (IDLE) → `read_rq_rdy`=1 after edge N.
- `buffer_id_valid` first sampled high at edge M → `read_rq_rdy`=0 after edge M; id latched at M.
- `buffer_id_valid` sampled low at edge K (RELEASE) → `frame_ready`=1 after edge K.
  - Minimum grant-to-ready latency: 2 cycles.
- `frame_done` sampled at edge D → `finalize_rd` high for exactly the cycle after D; IDLE after D+1.
  - Earliest next `read_rq_rdy` is after D+2 (`frame_rq` sampled at D+2).
- `read_rq_rdy` and `finalize_rd` are never high in the same cycle.

## Structure
- Shared package `buffer_pkg`:
  - `BUFFER_ID_WIDTH`=2, `NUM_BUFFERS`=3, `BUFFER_ID_INVALID`=2'd3.
  - State enum `rd_req_state_t` {IDLE, REQUEST, RELEASE, RELEASE_ERR, ACTIVE, FINALIZE}.
  - The package is shared with `BufferController` and a future write-side requester.
- No sub-module. The stride multiply is a constant multiply by a 2-bit id.

## Test plan
- Against a real `BufferController`, perform one write and write-finalize, then `frame_rq` → `read_rq_rdy` rises one cycle later, `frame_ready`=1 with id 0 and address 0, and `frame_done` produces a single-cycle `finalize_rd`.
- Run a 10-iteration loop of write(id (i+1)%3) / read / finalize_rd / finalize_wr → read ids are 0,1,2,0,1,…, each `frame_base_addr` = id × 21'h40000, and `timeout` and `proto_err` stay 0.
- Stub controller returns id 3, then later id 2 → `proto_err`=1, no `frame_ready` for id 3, re-request after valid drops, then `frame_ready` with id 2 and address 21'h80000.
- Stub never grants, with TIMEOUT_CYCLES=16 → `timeout` rises after 16 request cycles and `read_rq_rdy` stays 1. A later grant yields `frame_ready`=1.
- In ACTIVE, drive `frame_rq` and `frame_done` in the same cycle → exactly one `finalize_rd` pulse, IDLE, and no new request until `frame_rq` is re-asserted.
- Assert `reset_n`=0 while in REQUEST and then in ACTIVE → all outputs are 0 immediately, and the state is IDLE after release.

Source files
------------

// File: rtl/buffer_pkg.sv
// Types and constants shared by the triple-buffer controller and its
// read/write requesters.
package buffer_pkg;

  localparam int unsigned BUFFER_ID_WIDTH = 2;
  localparam int unsigned NUM_BUFFERS     = 3;

  // Index the controller must never grant; only ids 0..NUM_BUFFERS-1 are real buffers.
  localparam logic [BUFFER_ID_WIDTH-1:0] BUFFER_ID_INVALID = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    RELEASE,
    RELEASE_ERR,
    ACTIVE,
    FINALIZE
  } rd_req_state_t;

endpackage

// File: rtl/buffer_read_requester.sv
// Read-side initiator for the triple-buffer handshake: requests a buffer,
// owns it for one frame, then hands it back with a single finalize pulse.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | no buffer owned, waiting for frame_rq
// REQUEST     | read_rq_rdy held high, counting cycles toward timeout
// RELEASE     | valid id latched, waiting for the grant strobe to drop
// RELEASE_ERR | controller granted the invalid id, waiting for strobe to drop
// ACTIVE      | buffer owned, frame_ready high until frame_done
// FINALIZE    | single cycle of finalize_rd, then back to IDLE
module buffer_read_requester
  import buffer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 21,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE   = 21'h40000,
  parameter int unsigned           TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_rq,
  input  logic                       frame_done,
  output logic                       frame_ready,
  output logic [BUFFER_ID_WIDTH-1:0] frame_buffer_id,
  output logic [ADDR_WIDTH-1:0]      frame_base_addr,
  output logic                       read_rq_rdy,
  output logic                       finalize_rd,
  input  logic                       buffer_id_valid,
  input  logic [BUFFER_ID_WIDTH-1:0] buffer_id,
  output logic                       timeout,
  output logic                       proto_err
);

  // Counter only needs to reach TIMEOUT_CYCLES-1, where it parks.
  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rd_req_state_t               state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        rq_q;
  logic                        fin_q;
  logic                        ready_q;
  logic                        to_q;
  logic                        perr_q;
  logic [BUFFER_ID_WIDTH-1:0]  id_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [ADDR_WIDTH-1:0]       addr_d;

  // Base address of the offered id: a 2-bit id times a constant is just a select.
  always_comb begin
    addr_d = '0;
    case (buffer_id)
      2'd1:    addr_d = FRAME_STRIDE;
      2'd2:    addr_d = {FRAME_STRIDE[ADDR_WIDTH-2:0], 1'b0};
      default: addr_d = '0;
    endcase
  end

  // Handshake sequencing with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rq_q    <= 1'b0;
      fin_q   <= 1'b0;
      ready_q <= 1'b0;
      to_q    <= 1'b0;
      perr_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_rq) begin
            state_q <= REQUEST;
            rq_q    <= 1'b1;
            cnt_q   <= '0;
          end
        end
        REQUEST: begin
          if (buffer_id_valid) begin
            rq_q <= 1'b0;
            if (buffer_id == BUFFER_ID_INVALID) begin
              perr_q  <= 1'b1;
              state_q <= RELEASE_ERR;
            end else begin
              id_q    <= buffer_id;
              addr_q  <= addr_d;
              state_q <= RELEASE;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Keep requesting after a timeout; a late grant is still honoured.
            to_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!buffer_id_valid) begin
            state_q <= ACTIVE;
            ready_q <= 1'b1;
          end
        end
        RELEASE_ERR: begin
          if (!buffer_id_valid) begin
            state_q <= REQUEST;
            rq_q    <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ACTIVE: begin
          // frame_rq is deliberately ignored here, even when it arrives with frame_done.
          if (frame_done) begin
            state_q <= FINALIZE;
            ready_q <= 1'b0;
            fin_q   <= 1'b1;
          end
        end
        FINALIZE: begin
          fin_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rq_q    <= 1'b0;
          fin_q   <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign frame_ready     = ready_q;
  assign frame_buffer_id = id_q;
  assign frame_base_addr = addr_q;
  assign read_rq_rdy     = rq_q;
  assign finalize_rd     = fin_q;
  assign timeout         = to_q;
  assign proto_err       = perr_q;

endmodule

// File: tb/tb_buffer_read_requester.sv
// Bench for buffer_read_requester with a scripted controller stub.
module tb_buffer_read_requester;

  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_rq;
  logic        frame_done;
  logic        frame_ready;
  logic [1:0]  frame_buffer_id;
  logic [20:0] frame_base_addr;
  logic        read_rq_rdy;
  logic        finalize_rd;
  logic        buffer_id_valid;
  logic [1:0]  buffer_id;
  logic        timeout;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  buffer_read_requester #(
    .ADDR_WIDTH     (21),
    .FRAME_STRIDE   (21'h40000),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_rq        (frame_rq),
    .frame_done      (frame_done),
    .frame_ready     (frame_ready),
    .frame_buffer_id (frame_buffer_id),
    .frame_base_addr (frame_base_addr),
    .read_rq_rdy     (read_rq_rdy),
    .finalize_rd     (finalize_rd),
    .buffer_id_valid (buffer_id_valid),
    .buffer_id       (buffer_id),
    .timeout         (timeout),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Protocol-level model: what the requester owes the controller and reader.
  bit          m_rq, m_ready, m_fin, m_wait_low, m_err, m_to, m_pe;
  logic [1:0]  m_id;
  logic [20:0] m_addr;
  int          m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rq = 0; m_ready = 0; m_fin = 0; m_wait_low = 0; m_err = 0;
      m_to = 0; m_pe = 0; m_id = '0; m_addr = '0; m_cnt = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (m_ready) begin
      if (frame_done) begin
        m_ready = 0;
        m_fin   = 1;
      end
    end else if (m_wait_low) begin
      if (!buffer_id_valid) begin
        m_wait_low = 0;
        if (m_err) begin
          m_rq  = 1;
          m_cnt = 0;
        end else begin
          m_ready = 1;
        end
      end
    end else if (m_rq) begin
      if (buffer_id_valid) begin
        m_rq       = 0;
        m_wait_low = 1;
        if (buffer_id == 2'd3) begin
          m_err = 1;
          m_pe  = 1;
        end else begin
          m_err  = 0;
          m_id   = buffer_id;
          m_addr = 21'(32'(buffer_id) * 32'h40000);
        end
      end else begin
        m_cnt++;
        if (m_cnt >= TO_CYC) m_to = 1;
      end
    end else if (frame_rq) begin
      m_rq  = 1;
      m_cnt = 0;
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    chk("read_rq_rdy", 32'(read_rq_rdy), 32'(m_rq));
    chk("finalize_rd", 32'(finalize_rd), 32'(m_fin));
    chk("frame_ready", 32'(frame_ready), 32'(m_ready));
    chk("timeout",     32'(timeout),     32'(m_to));
    chk("proto_err",   32'(proto_err),   32'(m_pe));
    chk("rq_fin_excl", 32'(read_rq_rdy & finalize_rd), 32'd0);
    if (m_ready) begin
      chk("frame_buffer_id", 32'(frame_buffer_id), 32'(m_id));
      chk("frame_base_addr", 32'(frame_base_addr), 32'(m_addr));
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(string name);
    chk({name, "_rq"},    32'(read_rq_rdy),     32'd0);
    chk({name, "_fin"},   32'(finalize_rd),     32'd0);
    chk({name, "_ready"}, 32'(frame_ready),     32'd0);
    chk({name, "_id"},    32'(frame_buffer_id), 32'd0);
    chk({name, "_addr"},  32'(frame_base_addr), 32'd0);
    chk({name, "_to"},    32'(timeout),         32'd0);
    chk({name, "_perr"},  32'(proto_err),       32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    step(1);
    reset_n = 1'b1;
    step(1);
  endtask

  // Request, grant after 'delay' request cycles, consume, release.
  task automatic read_frame(logic [1:0] id, int delay, logic [20:0] exp_addr, bit rq_with_done);
    frame_rq = 1'b1;
    step(1);
    frame_rq = 1'b0;
    chk("rq_rise", 32'(read_rq_rdy), 32'd1);
    step(delay);
    buffer_id_valid = 1'b1;
    buffer_id       = id;
    step(1);
    buffer_id_valid = 1'b0;
    chk("rq_drop",      32'(read_rq_rdy), 32'd0);
    chk("ready_early",  32'(frame_ready), 32'd0);
    step(1);
    chk("ready_rise",   32'(frame_ready),     32'd1);
    chk("granted_id",   32'(frame_buffer_id), 32'(id));
    chk("granted_addr", 32'(frame_base_addr), 32'(exp_addr));
    step(2);
    chk("ready_hold",   32'(frame_ready), 32'd1);
    frame_done = 1'b1;
    frame_rq   = rq_with_done;
    step(1);
    frame_done = 1'b0;
    frame_rq   = 1'b0;
    chk("fin_pulse",    32'(finalize_rd), 32'd1);
    chk("ready_fall",   32'(frame_ready), 32'd0);
    step(1);
    chk("fin_end",      32'(finalize_rd), 32'd0);
    step(1);
  endtask

  initial begin
    logic [20:0] addr_tbl [3];
    addr_tbl[0] = 21'h00000;
    addr_tbl[1] = 21'h40000;
    addr_tbl[2] = 21'h80000;

    reset_n = 1'b0;
    frame_rq = 1'b0;
    frame_done = 1'b0;
    buffer_id_valid = 1'b0;
    buffer_id = 2'd0;
    step(2);
    chk_zero("reset");
    reset_n = 1'b1;
    step(2);

    // Round-robin reads with varied grant latency.
    for (int i = 0; i < 10; i++) begin
      read_frame(2'(i % 3), i % 5, addr_tbl[i % 3], 1'b0);
    end
    chk("loop_timeout", 32'(timeout),   32'd0);
    chk("loop_perr",    32'(proto_err), 32'd0);

    // Invalid id 3 held two cycles, then a valid grant of 2.
    frame_rq = 1'b1;
    step(1);
    frame_rq = 1'b0;
    step(2);
    buffer_id_valid = 1'b1;
    buffer_id       = 2'd3;
    step(1);
    chk("perr_set",     32'(proto_err),   32'd1);
    chk("perr_rq_drop", 32'(read_rq_rdy), 32'd0);
    step(1);
    chk("perr_wait",    32'(read_rq_rdy), 32'd0);
    buffer_id_valid = 1'b0;
    step(1);
    chk("perr_rerq",    32'(read_rq_rdy), 32'd1);
    chk("perr_noready", 32'(frame_ready), 32'd0);
    step(2);
    buffer_id_valid = 1'b1;
    buffer_id       = 2'd2;
    step(1);
    buffer_id_valid = 1'b0;
    step(1);
    chk("perr_ready",   32'(frame_ready),     32'd1);
    chk("perr_id2",     32'(frame_buffer_id), 32'd2);
    chk("perr_addr",    32'(frame_base_addr), 32'h80000);
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    step(2);
    chk("perr_sticky",  32'(proto_err), 32'd1);

    // Timeout: no grant for 16 request cycles, then a late grant.
    do_reset();
    frame_rq = 1'b1;
    step(1);
    frame_rq = 1'b0;
    step(TO_CYC - 1);
    chk("to_before",  32'(timeout),     32'd0);
    step(1);
    chk("to_set",     32'(timeout),     32'd1);
    chk("to_rq_hold", 32'(read_rq_rdy), 32'd1);
    step(3);
    buffer_id_valid = 1'b1;
    buffer_id       = 2'd1;
    step(1);
    buffer_id_valid = 1'b0;
    step(1);
    chk("to_ready",   32'(frame_ready),     32'd1);
    chk("to_addr",    32'(frame_base_addr), 32'h40000);
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    step(2);
    chk("to_sticky",  32'(timeout), 32'd1);

    // frame_rq together with frame_done is dropped.
    do_reset();
    read_frame(2'd2, 1, 21'h80000, 1'b1);
    step(3);
    chk("no_requeue", 32'(read_rq_rdy), 32'd0);
    read_frame(2'd0, 0, 21'h00000, 1'b0);

    // Reset in REQUEST, then in ACTIVE.
    frame_rq = 1'b1;
    step(1);
    frame_rq = 1'b0;
    step(2);
    do_reset();
    chk("rst_req_idle", 32'(read_rq_rdy), 32'd0);
    frame_rq = 1'b1;
    step(1);
    frame_rq = 1'b0;
    buffer_id_valid = 1'b1;
    buffer_id       = 2'd1;
    step(1);
    buffer_id_valid = 1'b0;
    step(2);
    chk("pre_rst_ready", 32'(frame_ready), 32'd1);
    do_reset();
    step(2);
    chk("rst_act_idle", 32'(frame_ready), 32'd0);
    read_frame(2'd1, 2, 21'h40000, 1'b0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
